// File: rtl/sokoban_pkg.sv
// Shared Sokoban display definitions.
// VGA timing, palette and cell index helper.
package sokoban_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] COL_MAN    = 12'hF80;
    localparam logic [11:0] COL_BOX_ON = 12'h0F0;
    localparam logic [11:0] COL_BOX    = 12'hA50;
    localparam logic [11:0] COL_DEST   = 12'hFF0;
    localparam logic [11:0] COL_WALL   = 12'h666;
    localparam logic [11:0] COL_WAY    = 12'hFFF;
    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_WIN    = 12'h0F0;

    function automatic logic [5:0] cell_idx(
        input logic [2:0] row,
        input logic [2:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/board_renderer_vga_timing.sv
// VGA raster counters with raw syncs and visible flag.
// Advances one pixel per pix_en strobe.
module vga_timing
    import sokoban_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible
);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] H_ON   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_OFF  = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] V_ON   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_OFF  = 10'(V_VIS + V_FP + V_SW);
    localparam logic [9:0] H_V    = 10'(H_VIS);
    localparam logic [9:0] V_V    = 10'(V_VIS);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Next raster position; the line counter steps when the pixel counter wraps
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Raster position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt     = h_cnt_q;
    assign v_cnt     = v_cnt_q;
    assign hsync_raw = !((h_cnt_q >= H_ON) && (h_cnt_q < H_OFF));
    assign vsync_raw = !((v_cnt_q >= V_ON) && (v_cnt_q < V_OFF));
    assign visible   = (h_cnt_q < H_V) && (v_cnt_q < V_V);

endmodule

// File: rtl/board_renderer.sv
// Sokoban 8x8 board to VGA pixel stream.
// Per-frame input snapshot, divider-free cell walk, 2-stage colour pipe.
module board_renderer
    import sokoban_pkg::*;
#(
    parameter int CELL_PX  = 48,
    parameter int BOARD_X0 = 128,
    parameter int BOARD_Y0 = 48,
    parameter int H_VIS    = H_VISIBLE,
    parameter int H_FP     = H_FRONT,
    parameter int H_SW     = H_SYNC,
    parameter int H_BP     = H_BACK,
    parameter int V_VIS    = V_VISIBLE,
    parameter int V_FP     = V_FRONT,
    parameter int V_SW     = V_SYNC,
    parameter int V_BP     = V_BACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [63:0] wall,
    input  logic [63:0] way,
    input  logic [63:0] box,
    input  logic [63:0] destination,
    input  logic [5:0]  man,
    input  logic        win,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int BOARD_PX = 8 * CELL_PX;
    localparam int SW       = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int H_TOT    = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SW + V_BP;
    localparam int HX_PRE   = (BOARD_X0 == 0) ? H_TOT - 1 : BOARD_X0 - 1;
    localparam int VY_PRE   = (BOARD_Y0 == 0) ? V_TOT - 1 : BOARD_Y0 - 1;
    localparam int BX_HI    = BOARD_X0 + BOARD_PX;
    localparam int BY_HI    = BOARD_Y0 + BOARD_PX;
    localparam int H_END    = H_TOT - 1;

    localparam logic [SW-1:0] SUB_MAX = SW'(CELL_PX - 1);
    localparam logic [9:0]    V_SNAP  = 10'(V_VIS);

    logic [9:0] h_cnt, v_cnt;
    logic       hsync_raw, vsync_raw, visible;
    int         hx, vy;
    logic       in_bx, in_by, in_brd, in_bdr, snap;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .visible   (visible)
    );

    assign hx          = 32'(h_cnt);
    assign vy          = 32'(v_cnt);
    assign snap        = pix_en && (h_cnt == 10'd0) && (v_cnt == V_SNAP);
    assign frame_start = snap;

    // Shadow copies of the board, refreshed only at the snapshot point
    logic [63:0] wall_q, wall_d, way_q, way_d;
    logic [63:0] box_q, box_d, dest_q, dest_d;
    logic [5:0]  man_q, man_d;
    logic        win_q, win_d;

    // Cell walk state and pipeline registers
    logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [2:0]    col_q, col_d, row_q, row_d;
    logic [5:0]    idx_q, idx_d;
    logic          brd_q, brd_d, bdr_q, bdr_d, vis_q, vis_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d;
    logic [11:0]   rgb_q, rgb_d, colour;
    logic          hs_q, hs_d, vs_q, vs_d;

    // Region flags for the pixel at the current raster position
    always_comb begin
        in_bx  = (hx >= BOARD_X0) && (hx < BX_HI);
        in_by  = (vy >= BOARD_Y0) && (vy < BY_HI);
        in_brd = in_bx && in_by;
        in_bdr = !in_brd
              && (hx >= BOARD_X0 - 4) && (hx < BX_HI + 4)
              && (vy >= BOARD_Y0 - 4) && (vy < BY_HI + 4);
    end

    // Column/row walk: cleared just before the board edge, stepped inside it
    always_comb begin
        sub_x_d = sub_x_q;
        col_d   = col_q;
        sub_y_d = sub_y_q;
        row_d   = row_q;
        if (pix_en) begin
            if (hx == HX_PRE) begin
                sub_x_d = '0;
                col_d   = '0;
            end else if (in_bx) begin
                if (sub_x_q == SUB_MAX) begin
                    sub_x_d = '0;
                    col_d   = col_q + 3'd1;
                end else begin
                    sub_x_d = sub_x_q + SW'(1);
                end
            end
            if (hx == H_END) begin
                if (vy == VY_PRE) begin
                    sub_y_d = '0;
                    row_d   = '0;
                end else if (in_by) begin
                    if (sub_y_q == SUB_MAX) begin
                        sub_y_d = '0;
                        row_d   = row_q + 3'd1;
                    end else begin
                        sub_y_d = sub_y_q + SW'(1);
                    end
                end
            end
        end
    end

    // Snapshot capture of all board inputs
    always_comb begin
        wall_d = snap ? wall        : wall_q;
        way_d  = snap ? way         : way_q;
        box_d  = snap ? box         : box_q;
        dest_d = snap ? destination : dest_q;
        man_d  = snap ? man         : man_q;
        win_d  = snap ? win         : win_q;
    end

    // Colour priority for the pixel held in stage 1
    always_comb begin
        colour = COL_BG;
        if (brd_q) begin
            if (man_q == idx_q)                      colour = COL_MAN;
            else if (box_q[idx_q] && dest_q[idx_q]) colour = COL_BOX_ON;
            else if (box_q[idx_q])                   colour = COL_BOX;
            else if (dest_q[idx_q])                  colour = COL_DEST;
            else if (wall_q[idx_q])                  colour = COL_WALL;
            else if (way_q[idx_q])                   colour = COL_WAY;
        end else if (bdr_q && win_q) begin
            colour = COL_WIN;
        end
    end

    // Two-stage pipeline, frozen while pix_en is low
    always_comb begin
        idx_d = idx_q;
        brd_d = brd_q;
        bdr_d = bdr_q;
        vis_d = vis_q;
        hs1_d = hs1_q;
        vs1_d = vs1_q;
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en) begin
            idx_d = cell_idx(row_q, col_q);
            brd_d = in_brd;
            bdr_d = in_bdr;
            vis_d = visible;
            hs1_d = hsync_raw;
            vs1_d = vsync_raw;
            rgb_d = vis_q ? colour : COL_BG;
            hs_d  = hs1_q;
            vs_d  = vs1_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wall_q  <= '0;
            way_q   <= '0;
            box_q   <= '0;
            dest_q  <= '0;
            man_q   <= '0;
            win_q   <= 1'b0;
            sub_x_q <= '0;
            sub_y_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            brd_q   <= 1'b0;
            bdr_q   <= 1'b0;
            vis_q   <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            wall_q  <= wall_d;
            way_q   <= way_d;
            box_q   <= box_d;
            dest_q  <= dest_d;
            man_q   <= man_d;
            win_q   <= win_d;
            sub_x_q <= sub_x_d;
            sub_y_q <= sub_y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            brd_q   <= brd_d;
            bdr_q   <= bdr_d;
            vis_q   <= vis_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer on a reduced raster.
// Expected pixels come from a geometric model of the board.
module tb_board_renderer;

    localparam int CELL = 4;
    localparam int X0   = 8;
    localparam int Y0   = 6;
    localparam int HV = 48, HF = 4, HS = 6, HB = 6;
    localparam int VV = 44, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [13:0] RST_V = {1'b1, 1'b1, 12'h000};

    logic        clk, rst_n, pix_en;
    logic [63:0] wall, way, box, destination;
    logic [5:0]  man;
    logic        win;
    logic        hsync, vsync, frame_start;
    logic [11:0] rgb;

    board_renderer #(
        .CELL_PX(CELL), .BOARD_X0(X0), .BOARD_Y0(Y0),
        .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .wall        (wall),
        .way         (way),
        .box         (box),
        .destination (destination),
        .man         (man),
        .win         (win),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [13:0] v;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          mh, mv;
    logic [63:0] s_wall, s_way, s_box, s_dest;
    logic [5:0]  s_man;
    logic        s_win;
    logic        pend;
    logic [13:0] last_exp;

    function automatic logic [13:0] exp_pix(input int x, input int y);
        logic        hs, vs;
        logic [11:0] c;
        int          bx, by, bsz, i;
        hs  = !((x >= HV + HF) && (x < HV + HF + HS));
        vs  = !((y >= VV + VF) && (y < VV + VF + VS));
        c   = 12'h000;
        bx  = x - X0;
        by  = y - Y0;
        bsz = 8 * CELL;
        if (x < HV && y < VV) begin
            if (bx >= 0 && bx < bsz && by >= 0 && by < bsz) begin
                i = (by / CELL) * 8 + (bx / CELL);
                if (int'(s_man) == i)           c = 12'hF80;
                else if (s_box[i] && s_dest[i]) c = 12'h0F0;
                else if (s_box[i])              c = 12'hA50;
                else if (s_dest[i])             c = 12'hFF0;
                else if (s_wall[i])             c = 12'h666;
                else if (s_way[i])              c = 12'hFFF;
            end else if (s_win && bx >= -4 && bx < bsz + 4
                         && by >= -4 && by < bsz + 4) begin
                c = 12'h0F0;
            end
        end
        return {hs, vs, c};
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        s_wall = '0;
        s_way = '0;
        s_box = '0;
        s_dest = '0;
        s_man = '0;
        s_win = 1'b0;
        q.delete();
        q.push_back('{x: -1, y: -1, v: RST_V});
        pend = 1'b0;
        last_exp = RST_V;
    endtask

    // Reference raster: one expected pixel per pix_en edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (pix_en) begin
                if (mh == 0 && mv == VV) begin
                    s_wall = wall;
                    s_way  = way;
                    s_box  = box;
                    s_dest = destination;
                    s_man  = man;
                    s_win  = win;
                end
                q.push_back('{x: mh, y: mv, v: exp_pix(mh, mv)});
                mh = mh + 1;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic cmp(input string nm, input int x, input int y,
                       input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s x=%0d y=%0d got=%h expected=%h",
                     nm, x, y, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT advanced a pixel
    initial begin
        exp_t e;
        logic fs_exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cmp("reset", -1, -1, {hsync, vsync, rgb}, RST_V);
                cmp("reset_fs", -1, -1, {13'd0, frame_start}, 14'd0);
            end else begin
                if (pend) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pipe_empty got=queue_empty expected=entry");
                    end else begin
                        e = q.pop_front();
                        cmp("pixel", e.x, e.y, {hsync, vsync, rgb}, e.v);
                        last_exp = e.v;
                    end
                end else begin
                    cmp("hold", mh, mv, {hsync, vsync, rgb}, last_exp);
                end
                fs_exp = pix_en && (mh == 0) && (mv == VV);
                cmp("frame_start", mh, mv, {13'd0, frame_start},
                    {13'd0, fs_exp});
            end
        end
    end

    task automatic wait_pos(input int x, input int y, input int pct);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            pix_en = ($urandom_range(99) < pct);
            n++;
        end while (!(mh == x && mv == y) && n < 4 * FRAME);
        checks++;
        if (!(mh == x && mv == y)) begin
            failures++;
            $display("FAIL wait_pos got=%0d,%0d expected=%0d,%0d",
                     mh, mv, x, y);
        end
    endtask

    task automatic randomize_board();
        wall        = {$urandom, $urandom};
        way         = {$urandom, $urandom};
        box         = {$urandom, $urandom} & {$urandom, $urandom};
        destination = {$urandom, $urandom} & {$urandom, $urandom};
        man         = 6'($urandom_range(63));
        win         = 1'($urandom_range(1));
    endtask

    initial begin
        #(900000);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pix_en = 1'b1;
        wall = '0;
        way = '0;
        box = '0;
        destination = '0;
        man = '0;
        win = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;

        // man in cell 0 only
        wait_pos(1, VV, 100);
        box[9] = 1'b1;
        destination[9] = 1'b1;
        wall[9] = 1'b1;
        man = 6'd63;
        wait_pos(1, VV, 100);
        way = '1;
        wait_pos(1, VV, 100);
        wait_pos(0, 20, 100);
        way = '0;
        wait_pos(1, VV, 100);
        win = 1'b1;
        wait_pos(1, VV, 100);
        wait_pos(20, 10, 100);
        pix_en = 1'b0;
        repeat (50) @(posedge clk);
        #1 pix_en = 1'b1;
        wait_pos(1, VV, 100);

        for (int k = 0; k < 3; k++) begin
            wait_pos($urandom_range(HV - 1), $urandom_range(VV - 1), 75);
            randomize_board();
            wait_pos(1, VV, 75);
        end
        wait_pos(1, VV, 75);

        way = '1;
        wait_pos(10, 20, 100);
        #1 rst_n = 1'b0;
        #1 cmp("async_reset", -1, -1, {hsync, vsync, rgb},
               RST_V);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_pos(1, VV, 100);
        wait_pos(1, VV, 100);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
